// File: rtl/spi_slv_pkg.sv
// -----------------------------------------------------------------------------
// spi_slv_pkg
// Shared definitions for the SPI slave frame controller:
//   - state_t         : controller state encoding
//   - PAR_EVEN_SEED   : starting value of the even-parity accumulator
//   - par_bit_pos()   : zero-based position of the parity bit inside a frame
//   - onehot16()      : one-hot decode of a register address (up to 16 regs)
// -----------------------------------------------------------------------------
package spi_slv_pkg;

    typedef enum logic [2:0] {
        ST_RESET = 3'd0,
        ST_IDLE  = 3'd1,
        ST_ADDR  = 3'd2,
        ST_DATA  = 3'd3,
        ST_PAR   = 3'd4,
        ST_DONE  = 3'd5
    } state_t;

    // Even parity: XOR of address, data and parity bit must come out 0.
    localparam logic PAR_EVEN_SEED = 1'b0;

    // The parity bit follows the last data bit.
    function automatic int par_bit_pos(input int addr_w, input int data_w);
        return addr_w + data_w;
    endfunction

    // Callers narrow the result to their register count.
    function automatic logic [15:0] onehot16(input logic [3:0] idx);
        return 16'h0001 << idx;
    endfunction

endpackage

// File: rtl/spi_slave_ctrl.sv
// -----------------------------------------------------------------------------
// spi_slave_ctrl
// Frame controller for an SPI slave register block. A frame is ADDR_W address
// bits (MSB first) followed by DATA_W data bits; while data bits arrive the
// addressed datapath register is shift-enabled. Optional even-parity bit after
// the data when SPI_SLV_PARITY_EN is defined.
//
// Ports:
//   clk        in   SPI sample clock, rising edge
//   rst        in   asynchronous, active-high reset
//   cs_n       in   chip select, active low
//   sample     in   sampled MOSI bit
//   shift_en   out  [NUM_REGS] one-hot shift enable (combinational)
//   mux_sel    out  [ADDR_W]   MISO source select = captured address
//   reg_valid  out  [NUM_REGS] one-hot flag of last successfully written reg
//   dp_rst     out  datapath reset (RESET cycle and frame abort)
//   frame_done out  one-cycle pulse on good frame completion
//   frame_err  out  one-cycle pulse on abort or parity error
//
// Build macro: SPI_SLV_PARITY_EN adds the PAR state and parity accumulator.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// RESET    | after reset, datapath held in reset for one cycle
// IDLE     | waiting for cs_n low; first address bit captured here
// ADDR     | capturing remaining address bits
// DATA     | DATA_W cycles of shift_en to the addressed register
// PAR      | parity bit check (SPI_SLV_PARITY_EN only)
// DONE     | one-cycle gap; frame_done pulses, reg_valid updated
// -----------------------------------------------------------------------------
module spi_slave_ctrl
    import spi_slv_pkg::*;
#(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 2
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     cs_n,
    input  logic                     sample,
    output logic [(1<<ADDR_W)-1:0]   shift_en,
    output logic [ADDR_W-1:0]        mux_sel,
    output logic [(1<<ADDR_W)-1:0]   reg_valid,
    output logic                     dp_rst,
    output logic                     frame_done,
    output logic                     frame_err
);

    localparam int NUM_REGS = 1 << ADDR_W;
    localparam int MAX_W    = (ADDR_W > DATA_W) ? ADDR_W : DATA_W;
    localparam int CNT_W    = $clog2(MAX_W + 1);

    state_t                state, state_nxt;
    logic [CNT_W-1:0]      cnt, cnt_nxt;
    logic [ADDR_W-1:0]     addr, addr_nxt, addr_shift;
    logic [ADDR_W-1:0]     mux_nxt;
    logic [NUM_REGS-1:0]   valid_nxt, addr_oh;
    logic                  done_nxt, err_nxt, dprst_nxt;
`ifdef SPI_SLV_PARITY_EN
    logic                  par_acc, par_nxt;
`endif

    assign addr_shift = ADDR_W'({addr, sample});
    assign addr_oh    = NUM_REGS'(onehot16(4'(addr)));
    assign shift_en   = (state == ST_DATA && !cs_n) ? addr_oh : '0;

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        addr_nxt  = addr;
        mux_nxt   = mux_sel;
        valid_nxt = reg_valid;
        done_nxt  = 1'b0;
        err_nxt   = 1'b0;
        dprst_nxt = 1'b0;
`ifdef SPI_SLV_PARITY_EN
        par_nxt   = par_acc;
`endif
        case (state)
            ST_RESET: begin
                state_nxt = ST_IDLE;
                cnt_nxt   = '0;
            end
            ST_IDLE: begin
                if (!cs_n) begin
                    addr_nxt = addr_shift;
`ifdef SPI_SLV_PARITY_EN
                    par_nxt  = PAR_EVEN_SEED ^ sample;
`endif
                    if (ADDR_W == 1) begin
                        state_nxt = ST_DATA;
                        cnt_nxt   = '0;
                        mux_nxt   = addr_shift;
                    end else begin
                        state_nxt = ST_ADDR;
                        cnt_nxt   = CNT_W'(1);
                    end
                end
            end
            ST_ADDR: begin
                if (cs_n) begin
                    state_nxt = ST_IDLE;
                    err_nxt   = 1'b1;
                    dprst_nxt = 1'b1;
                end else begin
                    addr_nxt = addr_shift;
`ifdef SPI_SLV_PARITY_EN
                    par_nxt  = par_acc ^ sample;
`endif
                    if (cnt == CNT_W'(ADDR_W - 1)) begin
                        state_nxt = ST_DATA;
                        cnt_nxt   = '0;
                        mux_nxt   = addr_shift;
                    end else begin
                        cnt_nxt = cnt + CNT_W'(1);
                    end
                end
            end
            ST_DATA: begin
                if (cs_n) begin
                    state_nxt = ST_IDLE;
                    err_nxt   = 1'b1;
                    dprst_nxt = 1'b1;
                end else begin
`ifdef SPI_SLV_PARITY_EN
                    par_nxt = par_acc ^ sample;
`endif
                    if (cnt == CNT_W'(DATA_W - 1)) begin
                        cnt_nxt = '0;
`ifdef SPI_SLV_PARITY_EN
                        state_nxt = ST_PAR;
`else
                        state_nxt = ST_DONE;
                        done_nxt  = 1'b1;
                        valid_nxt = addr_oh;
`endif
                    end else begin
                        cnt_nxt = cnt + CNT_W'(1);
                    end
                end
            end
`ifdef SPI_SLV_PARITY_EN
            ST_PAR: begin
                if (cs_n) begin
                    state_nxt = ST_IDLE;
                    err_nxt   = 1'b1;
                    dprst_nxt = 1'b1;
                end else if (par_acc ^ sample) begin
                    // Odd total: bad frame, keep previous reg_valid.
                    state_nxt = ST_IDLE;
                    err_nxt   = 1'b1;
                end else begin
                    state_nxt = ST_DONE;
                    done_nxt  = 1'b1;
                    valid_nxt = addr_oh;
                end
            end
`endif
            ST_DONE: begin
                state_nxt = ST_IDLE;
            end
            default: begin
                state_nxt = ST_RESET;
                dprst_nxt = 1'b1;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= ST_RESET;
            cnt        <= '0;
            addr       <= '0;
            mux_sel    <= '0;
            reg_valid  <= '0;
            frame_done <= 1'b0;
            frame_err  <= 1'b0;
            dp_rst     <= 1'b1;
        end else begin
            state      <= state_nxt;
            cnt        <= cnt_nxt;
            addr       <= addr_nxt;
            mux_sel    <= mux_nxt;
            reg_valid  <= valid_nxt;
            frame_done <= done_nxt;
            frame_err  <= err_nxt;
            dp_rst     <= dprst_nxt;
        end
    end

`ifdef SPI_SLV_PARITY_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            par_acc <= PAR_EVEN_SEED;
        end else begin
            par_acc <= par_nxt;
        end
    end
`endif

endmodule

// File: tb/tb_spi_slave_ctrl.sv
// -----------------------------------------------------------------------------
// tb_spi_slave_ctrl
// Directed bench for spi_slave_ctrl (ADDR_W=2, DATA_W=8). A frame-level model
// (bit position within the frame, address value, count of ones) predicts every
// output each cycle; literal checks pin specific frames. Honours
// SPI_SLV_PARITY_EN when defined.
// -----------------------------------------------------------------------------
module tb_spi_slave_ctrl;

    localparam int ADDR_W = 2;
    localparam int DATA_W = 8;
    localparam int NR     = 1 << ADDR_W;
`ifdef SPI_SLV_PARITY_EN
    localparam int PAR_BITS = 1;
`else
    localparam int PAR_BITS = 0;
`endif
    localparam int FL = ADDR_W + DATA_W + PAR_BITS;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              cs_n = 1'b1;
    logic              sample = 1'b0;
    logic [NR-1:0]     shift_en;
    logic [ADDR_W-1:0] mux_sel;
    logic [NR-1:0]     reg_valid;
    logic              dp_rst;
    logic              frame_done;
    logic              frame_err;

    int n_cmp = 0;
    int n_err = 0;

    spi_slave_ctrl #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) dut (
        .clk        (clk),
        .rst        (rst),
        .cs_n       (cs_n),
        .sample     (sample),
        .shift_en   (shift_en),
        .mux_sel    (mux_sel),
        .reg_valid  (reg_valid),
        .dp_rst     (dp_rst),
        .frame_done (frame_done),
        .frame_err  (frame_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s at %0t: got %0h, expected %0h", name, $time, act, exp);
        end
    endtask

    // ---------------- frame-level model ----------------
    int              pos     = -1;   // bits taken in current frame, -1 = none
    bit              m_first = 1'b1; // first cycle after reset
    bit              m_gap   = 1'b0; // one-cycle gap after a good frame
    int              m_addr  = 0;
    int              m_ones  = 0;
    logic [ADDR_W-1:0] e_mux   = '0;
    logic [NR-1:0]     e_valid = '0;
    logic              e_done  = 1'b0;
    logic              e_err   = 1'b0;
    logic              e_dprst = 1'b1;

    initial forever begin
        @(posedge clk or posedge rst);
        if (rst) begin
            pos = -1; m_first = 1'b1; m_gap = 1'b0; m_addr = 0; m_ones = 0;
            e_mux = '0; e_valid = '0; e_done = 1'b0; e_err = 1'b0; e_dprst = 1'b1;
        end else begin
            e_done = 1'b0; e_err = 1'b0; e_dprst = 1'b0;
            if (m_first) begin
                m_first = 1'b0;
            end else if (m_gap) begin
                m_gap = 1'b0;
            end else if (cs_n) begin
                if (pos >= 0) begin
                    pos = -1; e_err = 1'b1; e_dprst = 1'b1;
                end
            end else begin
                if (pos < 0) begin
                    pos = 0; m_addr = 0; m_ones = 0;
                end
                if (pos < ADDR_W) m_addr = m_addr * 2 + int'(sample);
                m_ones += int'(sample);
                pos++;
                if (pos == ADDR_W) e_mux = m_addr[ADDR_W-1:0];
                if (pos == FL) begin
                    if (PAR_BITS == 0 || (m_ones % 2) == 0) begin
                        e_done = 1'b1; e_valid = NR'(1) << m_addr; m_gap = 1'b1;
                    end else begin
                        e_err = 1'b1;
                    end
                    pos = -1;
                end
            end
        end
    end

    // ---------------- per-cycle compare ----------------
    initial forever begin
        logic [NR-1:0] e_se;
        @(negedge clk);
        e_se = (pos >= ADDR_W && pos < ADDR_W + DATA_W && !cs_n) ? (NR'(1) << m_addr) : '0;
        check("shift_en", 32'(shift_en), 32'(e_se));
        check("mux_sel", 32'(mux_sel), 32'(e_mux));
        check("reg_valid", 32'(reg_valid), 32'(e_valid));
        check("frame_done", 32'(frame_done), 32'(e_done));
        check("frame_err", 32'(frame_err), 32'(e_err));
        check("dp_rst", 32'(dp_rst), 32'(e_dprst));
    end

    // ---------------- stimulus ----------------
    task automatic drive(input logic c, input logic s);
        @(posedge clk);
        #1;
        cs_n = c;
        sample = s;
        @(negedge clk);
    endtask

    task automatic send_frame(input int a, input int d, input bit bad_par, input logic [NR-1:0] exp_se);
        logic [ADDR_W-1:0] av;
        logic [DATA_W-1:0] dv;
        av = ADDR_W'(a);
        dv = DATA_W'(d);
        for (int i = ADDR_W - 1; i >= 0; i--) drive(1'b0, av[i]);
        for (int i = DATA_W - 1; i >= 0; i--) begin
            drive(1'b0, dv[i]);
            check("lit_shift_en", 32'(shift_en), 32'(exp_se));
            if (i == DATA_W - 1) check("lit_mux_sel", 32'(mux_sel), 32'(a));
        end
`ifdef SPI_SLV_PARITY_EN
        drive(1'b0, (^{av, dv}) ^ bad_par);
        check("lit_par_shift_en", 32'(shift_en), 32'(0));
`else
        if (bad_par) $display("note: parity not built in, bad_par ignored");
`endif
    endtask

    initial begin
        // Reset state
        #12;
        check("rst_shift_en", 32'(shift_en), 32'(0));
        check("rst_mux_sel", 32'(mux_sel), 32'(0));
        check("rst_reg_valid", 32'(reg_valid), 32'(0));
        check("rst_frame_done", 32'(frame_done), 32'(0));
        check("rst_frame_err", 32'(frame_err), 32'(0));
        check("rst_dp_rst", 32'(dp_rst), 32'(1));
        #10 rst = 1'b0;
        drive(1'b1, 1'b0);
        check("idle_dp_rst", 32'(dp_rst), 32'(0));
        drive(1'b1, 1'b0);

        // Frame to address 2
        send_frame(2, 8'hA5, 1'b0, 4'b0100);
        drive(1'b1, 1'b0);
        check("f1_done", 32'(frame_done), 32'(1));
        check("f1_valid", 32'(reg_valid), 32'b0100);
        check("f1_mux", 32'(mux_sel), 32'd2);
        drive(1'b1, 1'b0);
        check("f1_done_clr", 32'(frame_done), 32'(0));
        check("f1_no_err", 32'(frame_err), 32'(0));

        // Abort after 3 data bits to address 1
        drive(1'b0, 1'b0);
        drive(1'b0, 1'b1);
        for (int i = 0; i < 3; i++) drive(1'b0, 1'b1);
        drive(1'b1, 1'b0);
        check("abort_shift_en", 32'(shift_en), 32'(0));
        drive(1'b1, 1'b0);
        check("abort_err", 32'(frame_err), 32'(1));
        check("abort_dp_rst", 32'(dp_rst), 32'(1));
        check("abort_valid", 32'(reg_valid), 32'b0100);
        check("abort_no_done", 32'(frame_done), 32'(0));
        drive(1'b1, 1'b0);
        check("abort_err_clr", 32'(frame_err), 32'(0));

        // Back-to-back frames, cs_n held low
        send_frame(3, 8'h3C, 1'b0, 4'b1000);
        drive(1'b0, 1'b1);
        check("b2b_gap_done", 32'(frame_done), 32'(1));
        check("b2b_gap_valid", 32'(reg_valid), 32'b1000);
        check("b2b_gap_shift", 32'(shift_en), 32'(0));
        send_frame(0, 8'hFF, 1'b0, 4'b0001);
        drive(1'b1, 1'b0);
        check("b2b2_done", 32'(frame_done), 32'(1));
        check("b2b2_valid", 32'(reg_valid), 32'b0001);
        drive(1'b1, 1'b0);

`ifdef SPI_SLV_PARITY_EN
        // Parity: wrong then right, address 1, data A5
        send_frame(1, 8'hA5, 1'b1, 4'b0010);
        drive(1'b1, 1'b0);
        check("par_bad_err", 32'(frame_err), 32'(1));
        check("par_bad_done", 32'(frame_done), 32'(0));
        check("par_bad_valid", 32'(reg_valid), 32'b0001);
        drive(1'b1, 1'b0);
        send_frame(1, 8'hA5, 1'b0, 4'b0010);
        drive(1'b1, 1'b0);
        check("par_ok_done", 32'(frame_done), 32'(1));
        check("par_ok_valid", 32'(reg_valid), 32'b0010);
        drive(1'b1, 1'b0);
`endif

        // Reset in 5th data cycle
        drive(1'b0, 1'b1);
        drive(1'b0, 1'b0);
        for (int i = 0; i < 5; i++) drive(1'b0, 1'b1);
        check("mid_shift_pre", 32'(shift_en), 32'b0100);
        #2;
        rst = 1'b1;
        cs_n = 1'b1;
        #1;
        check("mid_rst_shift", 32'(shift_en), 32'(0));
        check("mid_rst_valid", 32'(reg_valid), 32'(0));
        check("mid_rst_dp_rst", 32'(dp_rst), 32'(1));
        check("mid_rst_err", 32'(frame_err), 32'(0));
        @(negedge clk);
        #2 rst = 1'b0;
        drive(1'b1, 1'b0);
        check("post_rst_err", 32'(frame_err), 32'(0));
        check("post_rst_dp_rst", 32'(dp_rst), 32'(0));
        drive(1'b1, 1'b0);
        check("post_rst_err2", 32'(frame_err), 32'(0));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/spi_slave_ctrl.md
SPI_SLAVE_CTRL -- requirements
Module: spi_slave_ctrl

Interface
REQ-001 SHALL have parameter DATA_W, default 8, data bits per frame (2..32).
REQ-002 SHALL have parameter ADDR_W, default 2, address bits per frame (1..4); NUM_REGS = 2**ADDR_W.
REQ-003 SHALL have port clk  input  1  SPI sample clock; all state changes on rising edge.
REQ-004 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-005 SHALL have port cs_n  input  1  chip select, active-low.
REQ-006 SHALL have port sample  input  1  sampled MOSI bit, address MSB first, then data.
REQ-007 SHALL have port shift_en  output  NUM_REGS  one-hot shift enable to the addressed datapath register.
REQ-008 SHALL have port mux_sel  output  ADDR_W  MISO source select, equal to the captured address.
REQ-009 SHALL have port reg_valid  output  NUM_REGS  one-hot flag for the last successfully written register (status/LED enable).
REQ-010 SHALL have port dp_rst  output  1  datapath reset pulse.
REQ-011 SHALL have port frame_done  output  1  one-cycle pulse on frame completion.
REQ-012 SHALL have port frame_err  output  1  one-cycle pulse on frame abort or error.

Function
REQ-013 SHALL implement the states RESET, IDLE, ADDR, DATA, PAR (macro only) and DONE, with a bit counter of width clog2(max(ADDR_W,DATA_W)+1).
REQ-014 SHALL go RESET->IDLE unconditionally, with dp_rst=1 during RESET.
REQ-015 In IDLE with cs_n=0, SHALL shift sample into the address register and set the count to 1, then go to DATA if ADDR_W==1, else to ADDR.
REQ-016 In ADDR, SHALL shift one address bit per cycle and go to DATA on the cycle the ADDR_W-th bit is captured.
REQ-017 In DATA, SHALL assert shift_en[addr] for exactly DATA_W consecutive cycles, with all other shift_en bits 0, then go to DONE (or PAR with macro).
REQ-018 SHALL hold mux_sel at the captured address from the first DATA cycle until the next address capture; mux_sel SHALL be 0 after reset.
REQ-019 In DONE, SHALL pulse frame_done, load reg_valid with one-hot(addr), and go to IDLE; with cs_n held low, the next frame starts in IDLE, giving a one-cycle DONE gap between frames.
REQ-020 On cs_n=1 in ADDR, DATA or PAR, SHALL go to IDLE next cycle and pulse frame_err and dp_rst; shift_en SHALL be 0 combinationally in that cycle and reg_valid SHALL be unchanged.
REQ-021 cs_n=1 in IDLE or DONE SHALL NOT count as an error.
REQ-022 shift_en SHALL decode combinationally as (state==DATA) & ~cs_n & one-hot(addr); all other outputs SHALL be registered.

Reset
REQ-023 rst SHALL force state RESET, count=0, addr=0, mux_sel=0, reg_valid=0, frame_done=0, frame_err=0, shift_en=0, dp_rst=1.
REQ-024 rst mid-frame SHALL discard the frame without a frame_err pulse.

Configuration
REQ-025 With SPI_SLV_PARITY_EN defined, SHALL add state PAR after DATA, consuming one even-parity bit over address and data; on mismatch SHALL pulse frame_err, leave reg_valid unchanged, and skip the frame_done pulse.
REQ-026 Without SPI_SLV_PARITY_EN, SHALL omit PAR and its parity accumulator, making the frame exactly ADDR_W+DATA_W cycles.

Structure
REQ-027 State encoding (localparam enum) and parity-bit position constants SHALL live in shared package spi_slv_pkg.
REQ-028 SHALL be a single module with no sub-modules; the one-hot decode SHALL be a function in spi_slv_pkg.

Verification (ADDR_W=2, DATA_W=8)
REQ-029 Bench SHALL check: rst pulse -> all outputs 0 except dp_rst=1 for the RESET cycle, then IDLE.
REQ-030 Bench SHALL check: cs_n low, address bits 1,0 then 8 data bits -> shift_en=4'b0100 for exactly 8 cycles, mux_sel=2'd2, frame_done pulse, reg_valid=4'b0100.
REQ-031 Bench SHALL check: cs_n high after 3 data bits -> frame_err and dp_rst pulse, shift_en=0 that cycle, reg_valid unchanged.
REQ-032 Bench SHALL check: two back-to-back frames, addresses 3 then 0, cs_n held low -> one-cycle DONE gap, reg_valid 4'b1000 then 4'b0001.
REQ-033 Bench SHALL check, with SPI_SLV_PARITY_EN: address 1, data 8'hA5, wrong parity bit -> frame_err, no frame_done, reg_valid unchanged; correct parity -> reg_valid=4'b0010.
REQ-034 Bench SHALL check: rst asserted in the 5th DATA cycle -> immediate RESET, no frame_err, reg_valid=0.
